// File: rtl/reg_alu_seq.sv
// rtl/reg_alu_seq.sv - imem-driven command sequencer for the reg_alu block
// Define REG_ALU_SEQ_CAPTURE_EN to build the read-result and carry-count capture.
module reg_alu_seq #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [PC_W:0]   prog_len,
  output logic [PC_W-1:0] imem_addr,
  input  logic [20:0]     imem_data,
  output logic            sel,
  output logic            wr,
  output logic [1:0]      op,
  output logic [2:0]      rd_addr_a,
  output logic [2:0]      rd_addr_b,
  output logic [2:0]      wr_addr,
  output logic [7:0]      d_in,
  input  logic [7:0]      d_out_a,
  input  logic [7:0]      d_out_b,
  input  logic            cout,
  output logic            busy,
  output logic            done,
  output logic [7:0]      res_a,
  output logic [7:0]      res_b,
  output logic            res_cout,
  output logic [PC_W:0]   carry_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;

  localparam logic [PC_W-1:0] PC_ONE  = 1;
  localparam logic [PC_W:0]   LEN_ONE = 1;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W:0]   len_q, len_d;
  logic [20:0]     cmd_q, cmd_d;
  logic            last_cmd;
  logic            start_ok;

  assign last_cmd = ({1'b0, pc_q} == (len_q - LEN_ONE));
  assign start_ok = (state_q == S_IDLE) && start && !abort;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    cmd_d   = cmd_q;
    if (abort) begin
      state_d = S_IDLE;
      pc_d    = '0;
      len_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_d   = prog_len;
            pc_d    = '0;
            state_d = (prog_len == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          cmd_d   = imem_data;
          state_d = S_ISSUE;
        end
        S_ISSUE: begin
          // Stop on the last index rather than incrementing, so pc never wraps.
          if (last_cmd) begin
            state_d = S_DONE;
          end else begin
            pc_d    = pc_q + PC_ONE;
            state_d = S_FETCH;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      cmd_q   <= cmd_d;
    end
  end

  assign imem_addr = pc_q;
  assign sel       = cmd_q[20];
  assign wr        = (state_q == S_ISSUE) && cmd_q[19];
  assign op        = cmd_q[18:17];
  assign rd_addr_a = cmd_q[16:14];
  assign rd_addr_b = cmd_q[13:11];
  assign wr_addr   = cmd_q[10:8];
  assign d_in      = cmd_q[7:0];
  assign busy      = (state_q == S_FETCH) || (state_q == S_ISSUE);
  assign done      = (state_q == S_DONE);

`ifdef REG_ALU_SEQ_CAPTURE_EN
  logic [7:0]    res_a_q, res_a_d;
  logic [7:0]    res_b_q, res_b_d;
  logic          res_cout_q, res_cout_d;
  logic [PC_W:0] carry_cnt_q, carry_cnt_d;

  always_comb begin
    res_a_d     = res_a_q;
    res_b_d     = res_b_q;
    res_cout_d  = res_cout_q;
    carry_cnt_d = carry_cnt_q;
    if (start_ok) begin
      carry_cnt_d = '0;
    end
    if ((state_q == S_ISSUE) && !abort) begin
      if (!cmd_q[19]) begin
        res_a_d    = d_out_a;
        res_b_d    = d_out_b;
        res_cout_d = cout;
      end
      if (cmd_q[20] && cout && (carry_cnt_q != '1)) begin
        carry_cnt_d = carry_cnt_q + LEN_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_a_q     <= '0;
      res_b_q     <= '0;
      res_cout_q  <= 1'b0;
      carry_cnt_q <= '0;
    end else begin
      res_a_q     <= res_a_d;
      res_b_q     <= res_b_d;
      res_cout_q  <= res_cout_d;
      carry_cnt_q <= carry_cnt_d;
    end
  end

  assign res_a     = res_a_q;
  assign res_b     = res_b_q;
  assign res_cout  = res_cout_q;
  assign carry_cnt = carry_cnt_q;
`else
  logic unused_capture_inputs;
  assign unused_capture_inputs = ^{d_out_a, d_out_b, cout, start_ok};

  assign res_a     = '0;
  assign res_b     = '0;
  assign res_cout  = 1'b0;
  assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_reg_alu_seq.sv
// tb/tb_reg_alu_seq.sv - directed bench for reg_alu_seq with a behavioural reg_alu
module tb_reg_alu_seq;

`ifdef REG_ALU_SEQ_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  prog_len = '0;
  logic [3:0]  imem_addr;
  logic [20:0] imem_data;
  logic        sel, wr;
  logic [1:0]  op;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [7:0]  d_in, d_out_a, d_out_b;
  logic        cout, busy, done, res_cout;
  logic [7:0]  res_a, res_b;
  logic [4:0]  carry_cnt;

  logic [20:0] imem [16];
  logic [7:0]  regs [8];
  logic [8:0]  sum;
  logic        model_clr = 1'b1;

  int n_pass = 0;
  int n_total = 0;

  int         wr_cyc [$];
  logic [2:0] wa_log [$];
  logic [7:0] di_log [$];
  logic [3:0] fa_log [$];
  int         done_cyc;
  int         done_cnt;
  bit         busy_seen;

  reg_alu_seq #(.PC_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .prog_len(prog_len),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .sel(sel), .wr(wr), .op(op), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .wr_addr(wr_addr), .d_in(d_in), .d_out_a(d_out_a), .d_out_b(d_out_b), .cout(cout),
    .busy(busy), .done(done), .res_a(res_a), .res_b(res_b), .res_cout(res_cout),
    .carry_cnt(carry_cnt)
  );

  always #5 clk = ~clk;

  assign imem_data = imem[imem_addr];
  assign d_out_a   = regs[rd_addr_a];
  assign d_out_b   = regs[rd_addr_b];
  assign sum       = {1'b0, d_out_a} + {1'b0, d_out_b};
  assign cout      = sel & sum[8];

  always @(posedge clk) begin
    if (model_clr) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else if (wr) begin
      regs[wr_addr] <= sel ? sum[7:0] : d_in;
    end
  end

  task automatic load_write_prog();
    imem[0] = 21'b0_1_00_000_000_011_11001101;
    imem[1] = 21'b0_1_00_001_001_101_11100010;
    imem[2] = 21'b0_1_00_011_101_110_01010101;
    imem[3] = 21'b0_1_00_010_110_100_10101111;
  endtask

  // Start a program and log the bus cycle by cycle for a fixed window.
  task automatic run(input logic [4:0] len, input int budget, input int mid_cyc, input logic [4:0] mid_len);
    wr_cyc.delete(); wa_log.delete(); di_log.delete(); fa_log.delete();
    done_cyc = -1; done_cnt = 0; busy_seen = 1'b0;
    prog_len = len;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (wr === 1'b1) begin
        wr_cyc.push_back(c); wa_log.push_back(wr_addr); di_log.push_back(d_in);
      end
      if (busy === 1'b1) busy_seen = 1'b1;
      if ((c % 2 == 1) && (busy === 1'b1)) fa_log.push_back(imem_addr);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      start = (c == mid_cyc);
      if (c == mid_cyc) prog_len = mid_len;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if ({busy, done, wr} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, wr}); else n_pass++;
    n_total++; if (imem_addr !== 4'd0) $display("FAIL reset_pc got %0d want 0", imem_addr); else n_pass++;
    n_total++; if ({sel, op, rd_addr_a, rd_addr_b, wr_addr, d_in} !== 20'd0) $display("FAIL reset_cmd got %h want 0", {sel, op, rd_addr_a, rd_addr_b, wr_addr, d_in}); else n_pass++;
    n_total++; if ({res_a, res_b, res_cout, carry_cnt} !== 22'd0) $display("FAIL reset_res got %h want 0", {res_a, res_b, res_cout, carry_cnt}); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    model_clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_prog();
    logic [11:0] wa_pk;
    logic [31:0] di_pk;
    logic [31:0] cy_pk;
    load_write_prog();
    run(5'd4, 12, -1, 5'd0);
    wa_pk = '0; di_pk = '0; cy_pk = '0;
    foreach (wa_log[i]) wa_pk = {wa_pk[8:0], wa_log[i]};
    foreach (di_log[i]) di_pk = {di_pk[23:0], di_log[i]};
    foreach (wr_cyc[i]) cy_pk = {cy_pk[23:0], 8'(wr_cyc[i])};
    n_total++; if (wr_cyc.size() != 4) $display("FAIL write_count got %0d want 4", wr_cyc.size()); else n_pass++;
    n_total++; if (wa_pk !== {3'd3, 3'd5, 3'd6, 3'd4}) $display("FAIL write_addrs got %h want %h", wa_pk, {3'd3, 3'd5, 3'd6, 3'd4}); else n_pass++;
    n_total++; if (di_pk !== 32'hCDE255AF) $display("FAIL write_data got %h want CDE255AF", di_pk); else n_pass++;
    n_total++; if (cy_pk !== 32'h02040608) $display("FAIL write_cycles got %h want 02040608", cy_pk); else n_pass++;
    n_total++; if (done_cyc != 9 || done_cnt != 1) $display("FAIL write_done got cycle %0d count %0d want cycle 9 count 1", done_cyc, done_cnt); else n_pass++;
  endtask

  task automatic test_read_capture();
    imem[0] = 21'b0_0_00_011_101_010_00000000;
    run(5'd1, 6, -1, 5'd0);
    n_total++; if (wr_cyc.size() != 0) $display("FAIL read_no_wr got %0d pulses want 0", wr_cyc.size()); else n_pass++;
    n_total++; if (done_cyc != 3) $display("FAIL read_done got cycle %0d want 3", done_cyc); else n_pass++;
    n_total++; if (res_a !== (CAP ? 8'hCD : 8'h00)) $display("FAIL read_res_a got %h want %h", res_a, (CAP ? 8'hCD : 8'h00)); else n_pass++;
    n_total++; if (res_b !== (CAP ? 8'hE2 : 8'h00)) $display("FAIL read_res_b got %h want %h", res_b, (CAP ? 8'hE2 : 8'h00)); else n_pass++;
  endtask

  task automatic test_zero_len();
    run(5'd0, 4, -1, 5'd0);
    n_total++; if (done_cyc != 1 || done_cnt != 1) $display("FAIL zero_done got cycle %0d count %0d want cycle 1 count 1", done_cyc, done_cnt); else n_pass++;
    n_total++; if (busy_seen !== 1'b0) $display("FAIL zero_busy got %b want 0", busy_seen); else n_pass++;
    n_total++; if (wr_cyc.size() != 0) $display("FAIL zero_wr got %0d pulses want 0", wr_cyc.size()); else n_pass++;
  endtask

  task automatic test_abort();
    int extra_wr;
    int extra_done;
    logic [11:0] wa_pk;
    load_write_prog();
    prog_len = 5'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (wr !== 1'b1 || wr_addr !== 3'd5) $display("FAIL abort_second_issue got wr %b addr %0d want wr 1 addr 5", wr, wr_addr); else n_pass++;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_total++; if ({busy, wr, done} !== 3'b000) $display("FAIL abort_next_cycle got %b want 000", {busy, wr, done}); else n_pass++;
    extra_wr = 0; extra_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (wr === 1'b1) extra_wr++;
      if (done === 1'b1) extra_done++;
    end
    n_total++; if (extra_wr != 0 || extra_done != 0) $display("FAIL abort_quiet got wr %0d done %0d want 0 0", extra_wr, extra_done); else n_pass++;
    run(5'd4, 12, -1, 5'd0);
    wa_pk = '0;
    foreach (wa_log[i]) wa_pk = {wa_pk[8:0], wa_log[i]};
    n_total++; if (wr_cyc.size() != 4 || wa_pk !== {3'd3, 3'd5, 3'd6, 3'd4}) $display("FAIL abort_restart got %0d pulses addrs %h want 4 pulses %h", wr_cyc.size(), wa_pk, {3'd3, 3'd5, 3'd6, 3'd4}); else n_pass++;
    n_total++; if (done_cyc != 9) $display("FAIL abort_restart_done got cycle %0d want 9", done_cyc); else n_pass++;
  endtask

  task automatic test_start_ignored();
    imem[0] = 21'b0_1_00_000_000_001_00010001;
    imem[1] = 21'b0_1_00_000_000_010_00100010;
    imem[2] = 21'b0_1_00_000_000_001_00110011;
    imem[3] = 21'b0_1_00_000_000_010_01000100;
    run(5'd2, 12, 2, 5'd4);
    n_total++; if (done_cyc != 5 || done_cnt != 1) $display("FAIL busy_start_done got cycle %0d count %0d want cycle 5 count 1", done_cyc, done_cnt); else n_pass++;
    n_total++; if (wr_cyc.size() != 2) $display("FAIL busy_start_wr got %0d pulses want 2", wr_cyc.size()); else n_pass++;
  endtask

  task automatic test_full_len();
    int bad_addr;
    for (int i = 0; i < 16; i++) imem[i] = 21'b1_0_00_011_101_000_00000000;
    run(5'd16, 36, -1, 5'd0);
    bad_addr = 0;
    foreach (fa_log[i]) if (fa_log[i] !== 4'(i)) bad_addr++;
    n_total++; if (fa_log.size() != 16 || bad_addr != 0) $display("FAIL full_addrs got %0d fetches %0d out of order want 16 0", fa_log.size(), bad_addr); else n_pass++;
    n_total++; if (done_cyc != 33 || done_cnt != 1) $display("FAIL full_done got cycle %0d count %0d want cycle 33 count 1", done_cyc, done_cnt); else n_pass++;
    n_total++; if (carry_cnt !== (CAP ? 5'd16 : 5'd0)) $display("FAIL full_carry_cnt got %0d want %0d", carry_cnt, (CAP ? 5'd16 : 5'd0)); else n_pass++;
    n_total++; if (res_cout !== CAP) $display("FAIL full_res_cout got %b want %b", res_cout, CAP); else n_pass++;
  endtask

  task automatic test_reset_mid();
    load_write_prog();
    prog_len = 5'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (busy !== 1'b1 || imem_addr !== 4'd1) $display("FAIL midreset_pre got busy %b pc %0d want 1 1", busy, imem_addr); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_total++; if ({busy, done, wr, imem_addr} !== 7'd0) $display("FAIL midreset_ctrl got %b want 0", {busy, done, wr, imem_addr}); else n_pass++;
    n_total++; if ({sel, wr_addr, d_in, res_a, res_b, carry_cnt} !== 33'd0) $display("FAIL midreset_data got %h want 0", {sel, wr_addr, d_in, res_a, res_b, carry_cnt}); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) imem[i] = '0;
    test_reset();
    test_write_prog();
    test_read_capture();
    test_zero_len();
    test_abort();
    test_start_ignored();
    test_full_len();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_alu_seq.md
# reg_alu_seq

Command sequencer that drives the `reg_alu` register-file/ALU block from a small instruction memory. On `start` it fetches 21-bit command words from `imem`, issues each as a single-cycle command on the `reg_alu` control ports, optionally captures read/ALU results, and pulses `done` when the program ends. It replaces hand-applied test vectors as the initiator side of the `reg_alu` interface.

## Interface
- `PC_W`, default 4: program-counter width; max program length 2^PC_W.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: run request; sampled only in IDLE.
- `abort` in 1: synchronous abort; highest priority after reset.
- `prog_len` in PC_W+1: number of commands to run, 0..2^PC_W.
- `imem_addr` out PC_W: fetch address (= pc).
- `imem_data` in 21: command word `{sel, wr, op[1:0], rd_addr_a[2:0], rd_addr_b[2:0], wr_addr[2:0], d_in[7:0]}`; combinational read.
- `sel` out 1, `wr` out 1, `op` out 2, `rd_addr_a` out 3, `rd_addr_b` out 3, `wr_addr` out 3, `d_in` out 8: to `reg_alu`.
- `d_out_a` in 8, `d_out_b` in 8, `cout` in 1: from `reg_alu`.
- `busy` out 1: high in FETCH/ISSUE.
- `done` out 1: one-cycle pulse at program end.
- `res_a` out 8, `res_b` out 8, `res_cout` out 1, `carry_cnt` out PC_W+1: captured results (see Configuration).

## Operation
- FSM states: IDLE, FETCH, ISSUE, DONE.
- IDLE: `start`=1 -> FETCH with pc=0, or -> DONE if `prog_len`==0. `prog_len` is latched at start.
- FETCH: `imem_addr`=pc; at the edge, latch `imem_data` into the command register; -> ISSUE.
- ISSUE: command register drives all `reg_alu` ports. `wr` equals the command's wr bit in this state only.
  - At the edge: if pc == len-1 -> DONE, else pc+1 and -> FETCH.
- DONE: `done`=1 for one cycle; -> IDLE.
- Outside ISSUE, `wr` is forced to 0. All other command outputs hold their last issued value.
- `start` while busy: ignored.
- `abort`=1 in any state: -> IDLE at the next edge; no `done` pulse.
  - `wr` is already forced to 0 in the cycle after abort.
  - pc and the latched length are cleared.
- pc never wraps: the maximum `prog_len` of 2^PC_W ends at pc = 2^PC_W-1.

## Timing
- Reset (`reset`=0): state IDLE, and every output is 0 (pc, command register, `busy`, `done`, `res_*`, `carry_cnt`).
- Reset asserted mid-program: immediate return to IDLE with `wr`=0. This holds asynchronously.
- Latency:
  - start edge -> first ISSUE cycle: 2 cycles.
  - Throughput: 2 cycles per command.
  - N commands: `done` is high in cycle 2N+1 after the start edge.
  - `prog_len`=0: `done` is high in the cycle after start.
- `reg_alu` writes at the rising edge that ends the ISSUE cycle. `d_out_a`, `d_out_b` and `cout` are sampled at that same edge.

## Configuration
- `REG_ALU_SEQ_CAPTURE_EN` defined: result capture is enabled.
  - At the end of each ISSUE cycle whose wr=0, `d_out_a`, `d_out_b` and `cout` load into `res_a`, `res_b` and `res_cout`.
  - `carry_cnt` increments on every ISSUE cycle with sel=1 and `cout`=1. It saturates at all-ones.
  - `carry_cnt` clears on an accepted `start`. `res_*` hold until the next capture or reset.
- Not defined: `res_a`, `res_b`, `res_cout` and `carry_cnt` are tied to 0. No capture logic is built.

## Test plan
- Reset is released, `prog_len`=4, and imem holds the words:
  - `0_1_00_000_000_011_11001101`
  - `0_1_00_001_001_101_11100010`
  - `0_1_00_011_101_110_01010101`
  - `0_1_00_010_110_100_10101111`
  
  Required response: four 1-cycle `wr` pulses with `wr_addr` 3, 5, 6, 4 and `d_in` 0xCD, 0xE2, 0x55, 0xAF; `done` in cycle 9 after start.
- `prog_len`=1 with the word `0_0_00_011_101_010_0` (read) and capture enabled -> `res_a`=0xCD and `res_b`=0xE2 after ISSUE; `wr` never high.
- `prog_len`=0 -> `done` in the cycle after start; `busy` never high; no `wr`.
- `abort` asserted during the 2nd ISSUE of a 4-command program -> no further `wr` pulses, no `done`, `busy`=0 the next cycle. A new `start` then runs from pc=0.
- `reset` driven low mid-FETCH -> all outputs 0 immediately; `start` pulsed during busy is ignored (`prog_len` is not relatched).
- `prog_len`=16 (PC_W=4) with ALU add commands producing `cout`=1 -> `imem_addr` goes 0..15 with no wrap; `carry_cnt`=16 with the macro and 0 without.
